// File: rtl/eluks_wb_pkg.sv
// Shared constants and types for the ELUKS Wishbone register window.
package eluks_wb_pkg;

  localparam int unsigned OFFS_W   = 3;
  localparam int unsigned NUM_CFG  = 5;
  localparam int unsigned STATUS_W = 32;
  localparam int unsigned CNT_W    = 32;

  localparam logic [OFFS_W-1:0] PSW0        = 3'd0;
  localparam logic [OFFS_W-1:0] PSW1        = 3'd1;
  localparam logic [OFFS_W-1:0] START_BLOCK = 3'd2;
  localparam logic [OFFS_W-1:0] BLOCK_DIR   = 3'd3;
  localparam logic [OFFS_W-1:0] HMAC_EN     = 3'd4;
  localparam logic [OFFS_W-1:0] RQ_DATA     = 3'd5;
  localparam logic [OFFS_W-1:0] RQ_STATUS   = 3'd6;

  // Status word layout: {error, total_blocks}
  localparam int unsigned STATUS_ERR_BIT   = 31;
  localparam int unsigned STATUS_TOTAL_MSB = 30;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STATUS_WAIT,
    ST_BYTE_WAIT,
    ST_RESP,
    ST_HOLD
  } eluks_state_e;

endpackage

// File: rtl/eluks_wb_cfg_regs.sv
// Byte-lane-enabled configuration register file (offsets 0-4) with readback mux.
module eluks_wb_cfg_regs
  import eluks_wb_pkg::*;
#(
  parameter int unsigned WB_DATA = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 we_i,
  input  logic [OFFS_W-1:0]    offs_i,
  input  logic [WB_DATA/8-1:0] sel_i,
  input  logic [WB_DATA-1:0]   wdata_i,
  output logic [WB_DATA-1:0]   rdata_c_o,
  output logic [WB_DATA-1:0]   psw0_o,
  output logic [WB_DATA-1:0]   psw1_o,
  output logic [WB_DATA-1:0]   start_block_o,
  output logic [WB_DATA-1:0]   block_dir_o,
  output logic                 hmac_en_o
);

  localparam int unsigned NUM_LANES = WB_DATA / 8;

  logic [WB_DATA-1:0] regs_q [NUM_CFG];
  logic [WB_DATA-1:0] regs_d [NUM_CFG];

  // Merge only the enabled byte lanes of the addressed register
  always_comb begin
    regs_d = regs_q;
    if (we_i && (offs_i <= HMAC_EN)) begin
      for (int unsigned b = 0; b < NUM_LANES; b++) begin
        if (sel_i[b]) begin
          regs_d[offs_i][8*b +: 8] = wdata_i[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata_c_o     = (offs_i <= HMAC_EN) ? regs_q[offs_i] : '0;
  assign psw0_o        = regs_q[PSW0];
  assign psw1_o        = regs_q[PSW1];
  assign start_block_o = regs_q[START_BLOCK];
  assign block_dir_o   = regs_q[BLOCK_DIR];
  assign hmac_en_o     = regs_q[HMAC_EN][0];

endmodule

// File: rtl/eluks_wb_slave.sv
// Wishbone B4 classic responder for the ELUKS register window: config writes,
// status/byte handshakes with the decrypt core, late acks with held read data.
module eluks_wb_slave
  import eluks_wb_pkg::*;
#(
  parameter int unsigned        WB_DATA       = 32,
  parameter logic [WB_DATA-1:0] ELUKS_WB_ADDR = 32'h9200_0000,
  parameter logic [CNT_W-1:0]   TIMEOUT       = 32'h000F_FFFF
) (
  input  logic                   wb_clk,
  input  logic                   rst,
  input  logic [WB_DATA-1:0]     wb_adr_i,
  input  logic [WB_DATA-1:0]     wb_dat_i,
  input  logic [WB_DATA/8-1:0]   wb_sel_i,
  input  logic                   wb_we_i,
  input  logic                   wb_cyc_i,
  input  logic                   wb_stb_i,
  output logic [WB_DATA-1:0]     wb_dat_o,
  output logic                   wb_ack_o,
  output logic                   wb_err_o,
  output logic [2*WB_DATA-1:0]   psw,
  output logic [WB_DATA-1:0]     start_block,
  output logic [WB_DATA-1:0]     block_dir,
  output logic                   hmac_enable,
  output logic                   status_rq,
  input  logic                   status_vld,
  input  logic [STATUS_W-1:0]    status_i,
  output logic                   byte_rdy,
  input  logic                   byte_vld,
  input  logic [7:0]             byte_i
);

  eluks_state_e          state_q, state_d;
  logic [WB_DATA-1:0]    dat_q, dat_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic                  status_rq_q, status_rq_d;
  logic                  byte_rdy_q, byte_rdy_d;
  logic [STATUS_W-1:0]   status_q, status_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  hit_c;
  logic [OFFS_W-1:0]     offs_c;
  logic                  timeout_c;
  logic                  cfg_we_c;
  logic [WB_DATA-1:0]    cfg_rdata_c;
  logic [WB_DATA-1:0]    psw0, psw1;

  assign hit_c     = wb_cyc_i & wb_stb_i &
                     (wb_adr_i[WB_DATA-1:3] == ELUKS_WB_ADDR[WB_DATA-1:3]);
  assign offs_c    = wb_adr_i[OFFS_W-1:0];
  assign timeout_c = (cnt_q == TIMEOUT);

  eluks_wb_cfg_regs #(.WB_DATA(WB_DATA)) u_cfg (
    .clk_i         (wb_clk),
    .rst_i         (rst),
    .we_i          (cfg_we_c),
    .offs_i        (offs_c),
    .sel_i         (wb_sel_i),
    .wdata_i       (wb_dat_i),
    .rdata_c_o     (cfg_rdata_c),
    .psw0_o        (psw0),
    .psw1_o        (psw1),
    .start_block_o (start_block),
    .block_dir_o   (block_dir),
    .hmac_en_o     (hmac_enable)
  );

  // Next-state and registered-output logic; ack/err are set on the edge that
  // enters RESP/HOLD so they appear one cycle after the triggering event.
  always_comb begin
    state_d     = state_q;
    dat_d       = dat_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    status_rq_d = 1'b0;
    byte_rdy_d  = byte_rdy_q;
    status_d    = status_q;
    cnt_d       = timeout_c ? cnt_q : cnt_q + CNT_W'(1);
    cfg_we_c    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (hit_c) begin
          case (offs_c)
            PSW0, PSW1, START_BLOCK, BLOCK_DIR, HMAC_EN: begin
              cfg_we_c = wb_we_i;
              if (!wb_we_i) dat_d = cfg_rdata_c;
              ack_d   = 1'b1;
              state_d = ST_RESP;
            end
            RQ_DATA: begin
              byte_rdy_d = 1'b1;
              cnt_d      = '0;
              state_d    = ST_BYTE_WAIT;
            end
            RQ_STATUS: begin
              if (wb_we_i) begin
                status_rq_d = 1'b1;
                cnt_d       = '0;
                state_d     = ST_STATUS_WAIT;
              end else begin
                dat_d   = WB_DATA'(status_q);
                ack_d   = 1'b1;
                state_d = ST_RESP;
              end
            end
            default: begin
              err_d   = 1'b1;
              state_d = ST_HOLD;
            end
          endcase
        end
      end

      ST_STATUS_WAIT: begin
        if (status_vld) begin
          dat_d    = WB_DATA'(status_i);
          status_d = status_i;
          ack_d    = 1'b1;
          state_d  = ST_RESP;
        end else if (timeout_c) begin
          dat_d                 = '0;
          dat_d[STATUS_ERR_BIT] = 1'b1;
          ack_d                 = 1'b1;
          state_d               = ST_RESP;
        end
      end

      ST_BYTE_WAIT: begin
        // An abandoned cycle must not swallow a byte; a byte beats the timeout
        if (!wb_cyc_i) begin
          byte_rdy_d = 1'b0;
          state_d    = ST_IDLE;
        end else if (byte_vld && byte_rdy_q) begin
          dat_d      = WB_DATA'(byte_i);
          byte_rdy_d = 1'b0;
          ack_d      = 1'b1;
          state_d    = ST_RESP;
        end else if (timeout_c) begin
          byte_rdy_d = 1'b0;
          err_d      = 1'b1;
          state_d    = ST_HOLD;
        end
      end

      ST_RESP: state_d = ST_HOLD;

      ST_HOLD: begin
        if (!wb_stb_i) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      dat_q       <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      status_rq_q <= 1'b0;
      byte_rdy_q  <= 1'b0;
      status_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      dat_q       <= dat_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      status_rq_q <= status_rq_d;
      byte_rdy_q  <= byte_rdy_d;
      status_q    <= status_d;
      cnt_q       <= cnt_d;
    end
  end

  assign wb_dat_o  = dat_q;
  assign wb_ack_o  = ack_q;
  assign wb_err_o  = err_q;
  assign status_rq = status_rq_q;
  assign byte_rdy  = byte_rdy_q;
  assign psw       = {psw0, psw1};

endmodule

// File: tb/tb_eluks_wb_slave.sv
// Randomized bench for eluks_wb_slave against a transaction-level register/timing model.
module tb_eluks_wb_slave;

  localparam logic [31:0] BASE       = 32'h9200_0000;
  localparam int          TIMEOUT_TB = 16;
  // Counter is cleared at the hit edge and must count up to TIMEOUT before the
  // next edge fires, so the fallback response lands TIMEOUT+1 edges after the hit.
  localparam int          TO_LAT     = TIMEOUT_TB + 2;
  localparam int          BUDGET     = 64;

  logic        wb_clk = 1'b0;
  logic        rst;
  logic [31:0] wb_adr_i, wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i, wb_cyc_i, wb_stb_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, wb_err_o;
  logic [63:0] psw;
  logic [31:0] start_block, block_dir;
  logic        hmac_enable, status_rq, status_vld, byte_rdy, byte_vld;
  logic [31:0] status_i;
  logic [7:0]  byte_i;

  int n_checks = 0;
  int n_fail   = 0;
  int xact_id  = 0;

  logic [31:0] cfg_m [5];
  logic [31:0] status_m;
  logic [31:0] last_resp;

  always #5 wb_clk = ~wb_clk;

  eluks_wb_slave #(.TIMEOUT(32'd16)) dut (
    .wb_clk      (wb_clk),
    .rst         (rst),
    .wb_adr_i    (wb_adr_i),
    .wb_dat_i    (wb_dat_i),
    .wb_sel_i    (wb_sel_i),
    .wb_we_i     (wb_we_i),
    .wb_cyc_i    (wb_cyc_i),
    .wb_stb_i    (wb_stb_i),
    .wb_dat_o    (wb_dat_o),
    .wb_ack_o    (wb_ack_o),
    .wb_err_o    (wb_err_o),
    .psw         (psw),
    .start_block (start_block),
    .block_dir   (block_dir),
    .hmac_enable (hmac_enable),
    .status_rq   (status_rq),
    .status_vld  (status_vld),
    .status_i    (status_i),
    .byte_rdy    (byte_rdy),
    .byte_vld    (byte_vld),
    .byte_i      (byte_i)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) cfg_m[i] = '0;
    status_m  = '0;
    last_resp = '0;
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_psw"},   psw,         {cfg_m[0], cfg_m[1]});
    check_eq({tag, "_sblk"},  start_block, cfg_m[2]);
    check_eq({tag, "_bdir"},  block_dir,   cfg_m[3]);
    check_eq({tag, "_hmac"},  hmac_enable, cfg_m[4][0]);
    check_eq({tag, "_rdy"},   byte_rdy,    1'b0);
    check_eq({tag, "_dhold"}, wb_dat_o,    last_resp);
  endtask

  // One bus transaction with an optional core response after dly cycles (dly<=0: none)
  task automatic wb_xact(input logic [2:0] offs, input logic we, input logic [3:0] sel,
                         input logic [31:0] data, input int dly, input logic [31:0] val,
                         input int hold, output bit acked, output bit erred, output int lat,
                         output logic [31:0] rdat, output int n_ack, output int n_err,
                         output int n_rq);
    bit done;
    acked = 0; erred = 0; lat = 0; rdat = '0; n_ack = 0; n_err = 0; n_rq = 0; done = 0;
    @(posedge wb_clk); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_adr_i = BASE | 32'(offs);
    wb_we_i = we; wb_sel_i = sel; wb_dat_i = data;
    for (int k = 1; k <= BUDGET && !done; k++) begin
      if (k == 2 && offs == 3'd5) wb_we_i = 1'b0;
      if (offs == 3'd6 && we) begin
        status_vld = (dly > 0) && (k == dly + 1);
        status_i   = val;
      end else begin
        status_vld = 1'($urandom);
        status_i   = $urandom;
      end
      if (offs == 3'd5) begin
        byte_vld = (dly > 0) && (k == dly + 1);
        byte_i   = val[7:0];
      end else begin
        byte_vld = 1'($urandom);
        byte_i   = 8'($urandom);
      end
      @(posedge wb_clk); #1;
      n_ack += int'(wb_ack_o); n_err += int'(wb_err_o); n_rq += int'(status_rq);
      if (wb_ack_o || wb_err_o) begin
        acked = wb_ack_o; erred = wb_err_o; lat = k; rdat = wb_dat_o; done = 1;
      end
    end
    status_vld = 1'b0; byte_vld = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(posedge wb_clk); #1;
      n_ack += int'(wb_ack_o); n_err += int'(wb_err_o); n_rq += int'(status_rq);
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    for (int h = 0; h < 2; h++) begin
      @(posedge wb_clk); #1;
      n_ack += int'(wb_ack_o); n_err += int'(wb_err_o); n_rq += int'(status_rq);
    end
  endtask

  task automatic run_and_check(input logic [2:0] offs, input logic we, input logic [3:0] sel,
                               input logic [31:0] data, input int dly, input logic [31:0] val,
                               input int hold);
    bit exp_ack, exp_err, acked, erred;
    int exp_lat, lat, n_ack, n_err, n_rq;
    logic [31:0] exp_dat, rdat;
    string tg;
    xact_id++;
    tg = $sformatf("x%0d_o%0d", xact_id, offs);
    exp_ack = 0; exp_err = 0; exp_lat = 1; exp_dat = last_resp;
    if (offs <= 3'd4) begin
      exp_ack = 1;
      if (!we) exp_dat = cfg_m[offs];
    end else if (offs == 3'd5) begin
      if (dly > 0 && dly + 1 <= TO_LAT) begin
        exp_ack = 1; exp_lat = dly + 1; exp_dat = {24'h0, val[7:0]};
      end else begin
        exp_err = 1; exp_lat = TO_LAT;
      end
    end else if (offs == 3'd6) begin
      exp_ack = 1;
      if (!we) exp_dat = status_m;
      else if (dly > 0) begin exp_lat = dly + 1; exp_dat = val; end
      else begin exp_lat = TO_LAT; exp_dat = 32'h8000_0000; end
    end else begin
      exp_err = 1;
    end

    wb_xact(offs, we, sel, data, dly, val, hold, acked, erred, lat, rdat, n_ack, n_err, n_rq);

    check_eq({tg, "_ack"},  acked, exp_ack);
    check_eq({tg, "_err"},  erred, exp_err);
    check_eq({tg, "_lat"},  lat, exp_lat);
    check_eq({tg, "_nack"}, n_ack, exp_ack ? 1 : 0);
    check_eq({tg, "_nerr"}, n_err, exp_err ? 1 : 0);
    check_eq({tg, "_nrq"},  n_rq, (offs == 3'd6 && we) ? 1 : 0);
    if (exp_ack) check_eq({tg, "_dat"}, rdat, exp_dat);

    if (offs <= 3'd4 && we) begin
      for (int b = 0; b < 4; b++) if (sel[b]) cfg_m[offs][8*b +: 8] = data[8*b +: 8];
    end
    if (offs == 3'd6 && we && dly > 0) status_m = val;
    if (exp_ack) last_resp = exp_dat;
    check_outputs(tg);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pick;
    rst = 1'b1; wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0; wb_we_i = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; status_vld = 1'b0; status_i = '0;
    byte_vld = 1'b0; byte_i = '0;
    model_reset();
    repeat (3) @(posedge wb_clk);
    #1 rst = 1'b0;
    check_eq("rst_ack", wb_ack_o, 1'b0);
    check_eq("rst_err", wb_err_o, 1'b0);
    check_eq("rst_rq",  status_rq, 1'b0);
    check_outputs("rst");

    // Password, readback
    run_and_check(3'd0, 1'b1, 4'hF, 32'hDEAD_BEEF, 0, 0, 0);
    run_and_check(3'd1, 1'b1, 4'hF, 32'h0123_4567, 0, 0, 0);
    check_eq("psw_const", psw, 64'hDEAD_BEEF_0123_4567);
    run_and_check(3'd0, 1'b0, 4'hF, 32'h0, 0, 0, 0);
    check_eq("psw0_rb", wb_dat_o, 32'hDEAD_BEEF);

    // Partial lane write
    run_and_check(3'd2, 1'b1, 4'hF, 32'hFFFF_FFFF, 0, 0, 0);
    run_and_check(3'd2, 1'b1, 4'b0011, 32'hAAAA_5555, 0, 0, 0);
    check_eq("sblk_const", start_block, 32'hFFFF_5555);

    // Status request answered after 10 cycles; data must persist after the ack
    run_and_check(3'd6, 1'b1, 4'hF, 32'h1, 10, 32'h0000_0004, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge wb_clk); #1;
      check_eq($sformatf("st_hold%0d", i), wb_dat_o, 32'h4);
    end

    // Byte request, stb held long after the ack
    run_and_check(3'd5, 1'b1, 4'hF, 32'h0, 5, 32'h3C, 4);

    // Timeouts and the byte-vs-timeout boundary
    run_and_check(3'd6, 1'b1, 4'hF, 32'h1, 0, 0, 0);
    run_and_check(3'd5, 1'b1, 4'hF, 32'h0, 0, 0, 0);
    run_and_check(3'd5, 1'b0, 4'hF, 32'h0, TO_LAT - 1, 32'hA5, 0);
    run_and_check(3'd5, 1'b1, 4'hF, 32'h0, TO_LAT, 32'h5A, 0);
    run_and_check(3'd6, 1'b0, 4'hF, 32'h0, 0, 0, 0);

    // Invalid offset
    run_and_check(3'd7, 1'b0, 4'hF, 32'h0, 0, 0, 2);

    // Master abandons a byte request; a late byte must not be consumed
    @(posedge wb_clk); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_adr_i = BASE | 32'd5; wb_we_i = 1'b1;
    repeat (3) @(posedge wb_clk);
    #1 check_eq("drop_rdy1", byte_rdy, 1'b1);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(posedge wb_clk); #1;
    check_eq("drop_rdy0", byte_rdy, 1'b0);
    byte_vld = 1'b1; byte_i = 8'h77;
    @(posedge wb_clk); #1;
    byte_vld = 1'b0;
    check_eq("drop_ack", wb_ack_o, 1'b0);
    check_eq("drop_dat", wb_dat_o, last_resp);
    run_and_check(3'd0, 1'b0, 4'hF, 32'h0, 0, 0, 0);

    // Random traffic
    for (int t = 0; t < 60; t++) begin
      pick = int'($urandom_range(0, 11));
      if (pick <= 6)
        run_and_check(3'($urandom_range(0, 4)), 1'($urandom), 4'($urandom), $urandom, 0, 0,
                      int'($urandom_range(0, 2)));
      else if (pick == 7)  run_and_check(3'd6, 1'b0, 4'hF, 0, 0, 0, 0);
      else if (pick == 8)
        run_and_check(3'd6, 1'b1, 4'hF, 1, int'($urandom_range(1, TIMEOUT_TB - 1)), $urandom,
                      int'($urandom_range(0, 2)));
      else if (pick == 9)
        run_and_check(3'd5, 1'($urandom), 4'hF, 0, int'($urandom_range(1, TIMEOUT_TB + 3)),
                      $urandom, int'($urandom_range(0, 3)));
      else if (pick == 10) run_and_check(3'd7, 1'($urandom), 4'hF, 0, 0, 0, 0);
      else run_and_check(3'd6, 1'b1, 4'hF, 1, 0, 0, 0);
    end

    // Reset while waiting for a byte
    @(posedge wb_clk); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_adr_i = BASE | 32'd5; wb_we_i = 1'b1;
    repeat (3) @(posedge wb_clk);
    #1 check_eq("mrst_rdy1", byte_rdy, 1'b1);
    rst = 1'b1; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(posedge wb_clk); #1;
    rst = 1'b0;
    model_reset();
    check_eq("mrst_rdy0", byte_rdy, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("mrst_ack%0d", i), wb_ack_o, 1'b0);
      @(posedge wb_clk); #1;
    end
    check_outputs("mrst");
    run_and_check(3'd0, 1'b0, 4'hF, 32'h0, 0, 0, 0);
    run_and_check(3'd6, 1'b0, 4'hF, 32'h0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
